// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// AXI3 slave responder backed by a single word-organised RAM of 2^DEPTH_LOG2
// 32-bit words. It stands in for external memory in simulation and FPGA
// builds. Single-beat and INCR/FIXED bursts of up to 16 beats are supported,
// along with byte strobes and SLVERR responses for out-of-range addresses.
// Reads and writes are handled by independent state machines, so one read
// burst and one write burst can be in flight at the same time.
//
// Optional build macro:
//   AXI_SLV_STALL_EN - an 8-bit LFSR pseudo-randomly drops arready, awready
//                      and wready to exercise master back-pressure handling.
//                      rvalid and bvalid are never gated.
//
// Ports:
//   aclk, areset                      clock, asynchronous active-high reset
//   ar* / arvalid / arready           read address channel
//                                     (arlock/arcache/arprot ignored)
//   rid/rdata/rresp/rlast/rvalid/rready  read data channel
//   aw* / awvalid / awready           write address channel
//                                     (awlock/awcache/awprot ignored)
//   wid/wdata/wstrb/wlast/wvalid/wready  write data channel (wid ignored)
//   bid/bresp/bvalid/bready           write response channel
// -----------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,

    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,

    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,

    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,

    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    // Any address bit above the RAM's byte range makes the beat out of range.
    function automatic logic in_range(input logic [31:0] a);
        return a[31:DEPTH_LOG2+2] == '0;
    endfunction

    // FIXED keeps the address; every other burst code (WRAP included) steps
    // by the beat size, capped at one 32-bit word. The add wraps at 2^32.
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] step;
        step = (size >= 3'd2) ? 32'd4 : (32'd1 << size);
        return (burst == 2'b00) ? a : a + step;
    endfunction

    logic [31:0] mem [WORDS];

    logic stall;

    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [3:0]  r_beat;
    logic [31:0] r_next;
    logic [31:0] ar_word;
    logic [31:0] next_word;

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [3:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [3:0]  w_beat;
    logic        w_err;
    logic        w_fire;
    logic        w_beat_err;
    logic [31:0] w_next;

    logic        unused_inputs;
    assign unused_inputs = ^{arlock, arcache, arprot, arlen[7:4],
                             awlock, awcache, awprot, awlen[7:4], wid};

`ifdef AXI_SLV_STALL_EN
    // Fibonacci LFSR, taps 8,6,5,4; bit 0 decides whether the readies stall.
    logic [7:0] lfsr;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign arready = (r_state == R_IDLE) && !stall;
    assign awready = (w_state == W_IDLE) && !stall;
    assign wready  = (w_state == W_DATA) && !stall;

    // Read data is fetched one step ahead: on AR accept from araddr, and on
    // each non-last R handshake from the next beat address. Because the RAM
    // write lands on the same edge, a same-cycle collision returns old data.
    assign r_next    = next_addr(r_addr, r_size, r_burst);
    assign ar_word   = in_range(araddr) ? mem[araddr[DEPTH_LOG2+1:2]] : '0;
    assign next_word = in_range(r_next) ? mem[r_next[DEPTH_LOG2+1:2]] : '0;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rid     <= arid;
                        r_addr  <= araddr;
                        r_len   <= arlen[3:0];
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_beat  <= '0;
                        rdata   <= ar_word;
                        rresp   <= in_range(araddr) ? RESP_OKAY : RESP_SLVERR;
                        rlast   <= (arlen[3:0] == 4'd0);
                        rvalid  <= 1'b1;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 4'd1;
                            r_addr <= r_next;
                            rdata  <= next_word;
                            rresp  <= in_range(r_next) ? RESP_OKAY : RESP_SLVERR;
                            rlast  <= ((r_beat + 4'd1) == r_len);
                        end
                    end
                end
                default: begin
                    rvalid  <= 1'b0;
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // A beat is flagged if it is out of range or if the master's wlast does
    // not agree with the beat count derived from awlen.
    assign w_fire     = wvalid && wready;
    assign w_next     = next_addr(w_addr, w_size, w_burst);
    assign w_beat_err = !in_range(w_addr) || (wlast != (w_beat == w_len));
    assign bresp      = w_err ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
            bid     <= '0;
            bvalid  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        bid     <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen[3:0];
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_err <= w_err | w_beat_err;
                        // The burst ends on the beat count alone, not on wlast.
                        if (w_beat == w_len) begin
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 4'd1;
                            w_addr <= w_next;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    bvalid  <= 1'b0;
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // RAM contents survive reset; out-of-range beats are dropped here.
    always_ff @(posedge aclk) begin
        if (w_fire && in_range(w_addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[w_addr[DEPTH_LOG2+1:2]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule
